key_conditioner: RTL and testbench
==================================

# key_conditioner

Input conditioning stage between the DE1 board inputs (KEY[0:3], SW[0:9]) and the airlock `Interlock` controller. Each raw input is synchronized into the `clk` domain, debounced by a per-bit stability counter, and presented as a clean level. KEY inputs additionally produce single-cycle press pulses, so the interlock sees one command per physical button press. `Interlock` consumes only `key_level`, `key_press`, `sw_level` and `sw_change`, never raw pins.

## Interface

- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles an input must differ from its current debounced value before the value updates. Legal range is ≥1. Board builds override it (e.g. 500000).
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `KEY` in [0:3]: raw pushbuttons, active-low (0 = pressed), asynchronous to `clk`.
- `SW` in [0:9]: raw slide switches, active-high, asynchronous to `clk`.
- `key_level` out [0:3]: debounced button state, active-high (1 = pressed).
- `key_press` out [0:3]: one-cycle pulse per debounced press (0→1 of `key_level`).
- `sw_level` out [0:9]: debounced switch state.
- `sw_change` out 1: one-cycle pulse when any `sw_level` bit changes.

## Operation

- **Synchronizer:** each of the 14 inputs passes through a 2-flop synchronizer. KEY bits are inverted after synchronization, so all downstream logic is active-high.
- **Debounce:** each bit has a debounced value `s` and a counter `c`. The behaviour is fixed per bit; no shared counter.
  - Synchronized input == `s`: `c` <= 0.
  - Input != `s` and `c` == DEBOUNCE_CYCLES-1: `s` <= input, `c` <= 0.
  - Input != `s` otherwise: `c` <= `c`+1.
- **Glitch rejection:** any return to `s` before the count completes clears `c`, and there is no output change.
- **key_press[i]:** registered and asserted in the same cycle `key_level[i]` goes 0→1. It lasts exactly one cycle.
  - A held button gives no further pulses.
  - Release (1→0) gives no pulse.
- **sw_change:** registered and asserted in the same cycle any `sw_level` bit updates, in either direction. Simultaneous changes on several bits give one single-cycle pulse.
- **Independence:** bits are independent. Simultaneous presses on several keys pulse together in the same cycle.
- **Reset values (async, `rst`=0):**
  - KEY synchronizer flops = 1 (idle, unpressed); SW synchronizer flops = 0.
  - All `s` = 0 and all `c` = 0.
  - `key_level` = 0, `key_press` = 0, `sw_level` = 0, `sw_change` = 0.
- **Reset mid-debounce:** the count in progress is discarded and no pulse is emitted. Switches already up at reset release are debounced normally from `s`=0, so `sw_level` rises and `sw_change` pulses once.

## Timing

- **Latency:** raw input settled before rising edge k → synchronized value valid after edge k+1 → `key_level`/`sw_level` update at edge k+1+DEBOUNCE_CYCLES. That is DEBOUNCE_CYCLES+2 edges in total; with the default of 4, the update is at the 6th edge.
- `key_press` and `sw_change` are valid in the cycle following the same edge as the level update.
- **Minimum pulse accepted:** a bounce is filtered if it is seen at the synchronizer output for fewer than DEBOUNCE_CYCLES consecutive cycles.
- **DEBOUNCE_CYCLES=1:** the level follows the synchronized input with 3-edge latency. Pulses are still exactly one cycle.
- **Counter wrap:** `c` never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.

## Test plan

- **Reset state:** assert `rst`=0 with KEY=4'b1111, SW=0 → all outputs 0. Deassert, hold inputs for 20 cycles → outputs stay 0 and no pulses.
- **Clean press, default 4:** KEY[0] driven 0 before edge k → `key_level[0]`=1 after edge k+5. `key_press[0]`=1 for exactly that one cycle. Hold for 30 cycles → no further pulse. Release → `key_level[0]`=0 after 6 edges, no pulse.
- **Bounce rejection:** KEY[1] toggles 0/1 every 2 cycles for 20 cycles, then holds 0 → `key_level[1]` stays 0 during the toggling. It rises exactly 6 edges after the final settle, with one `key_press[1]` pulse.
- **Simultaneous events:** KEY[2], KEY[3] pressed on the same edge and SW[0], SW[9] set on the same edge → `key_press[2]` and `key_press[3]` pulse in the same cycle. `sw_level` becomes 10'b1000000001 with a single one-cycle `sw_change`.
- **Reset mid-operation:** press KEY[0], assert `rst` 3 cycles later (mid-count), release reset with KEY[0] still held → no pulse during or at reset. `key_level[0]` rises 6 edges after reset release, with one pulse.
- **Switches up at reset:** SW=10'h3FF throughout reset → `sw_level`=0 at release, then 10'h3FF after 6 edges with one `sw_change` pulse.

Source files
------------

// File: rtl/key_conditioner_if.sv
// Signal bundle between the raw DE1 pins, the input conditioner and the Interlock controller.
// The conditioner sits on the slave side: it takes the raw pins and produces clean levels and pulses.
interface key_conditioner_if;
    logic [0:3] KEY;
    logic [0:9] SW;
    logic [0:3] key_level;
    logic [0:3] key_press;
    logic [0:9] sw_level;
    logic       sw_change;

    modport master (
        output KEY, SW,
        input  key_level, key_press, sw_level, sw_change
    );

    modport slave (
        input  KEY, SW,
        output key_level, key_press, sw_level, sw_change
    );
endinterface

// File: rtl/key_conditioner.sv
// Synchronizes, debounces and edge-detects the DE1 pushbuttons and slide switches.
// Each of the 14 bits has its own stability counter; KEY bits are active-high after inversion.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst,
    key_conditioner_if.slave  bus
);

    localparam int NB = 14;
    localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [0:3]       key_meta, key_sync;
    logic [0:9]       sw_meta, sw_sync;
    logic [0:NB-1]    din;
    logic [0:NB-1]    s_q;
    logic [0:NB-1]    s_nxt;
    logic [CNT_W-1:0] cnt [0:NB-1];
    logic [0:3]       key_press_q;
    logic             sw_change_q;

    // KEY flops idle high so a reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_meta <= '1;
            key_sync <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= bus.KEY;
            key_sync <= key_meta;
            sw_meta  <= bus.SW;
            sw_sync  <= sw_meta;
        end
    end

    assign din = {~key_sync, sw_sync};

    always_comb begin
        s_nxt = s_q;
        for (int i = 0; i < NB; i++) begin
            if (din[i] != s_q[i] && cnt[i] == TC)
                s_nxt[i] = din[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q         <= '0;
            key_press_q <= '0;
            sw_change_q <= 1'b0;
            for (int i = 0; i < NB; i++)
                cnt[i] <= '0;
        end else begin
            s_q         <= s_nxt;
            key_press_q <= s_nxt[0:3] & ~s_q[0:3];
            sw_change_q <= |(s_nxt[4:13] ^ s_q[4:13]);
            for (int i = 0; i < NB; i++) begin
                if (din[i] == s_q[i] || cnt[i] == TC)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign bus.key_level = s_q[0:3];
    assign bus.sw_level  = s_q[4:13];
    assign bus.key_press = key_press_q;
    assign bus.sw_change = sw_change_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner at DEBOUNCE_CYCLES=4: levels settle 6 edges after an input change.
module tb_key_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   kp_cnt;
    int   sc_cnt;
    logic [0:3] lvl_or;

    key_conditioner_if bus ();

    key_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, tallying key/switch pulses and any key level seen.
    task automatic run(input int n);
        kp_cnt = 0;
        sc_cnt = 0;
        lvl_or = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.key_press != 4'b0000) kp_cnt++;
            if (bus.sw_change) sc_cnt++;
            lvl_or = lvl_or | bus.key_level;
        end
    endtask

    initial begin
        bus.KEY = 4'b1111;
        bus.SW  = 10'b0;

        // reset state
        run(3);
        check("rst_key_level", 32'(bus.key_level), 32'h0);
        check("rst_key_press", 32'(bus.key_press), 32'h0);
        check("rst_sw_level",  32'(bus.sw_level),  32'h0);
        check("rst_sw_change", 32'(bus.sw_change), 32'h0);
        rst = 1'b1;
        run(20);
        check("idle_press_cnt",  32'(kp_cnt), 32'd0);
        check("idle_change_cnt", 32'(sc_cnt), 32'd0);
        check("idle_level",      32'(lvl_or), 32'h0);

        // clean press on KEY[0]
        bus.KEY = 4'b0111;
        run(5);
        check("press_lvl_e5", 32'(bus.key_level), 32'h0);
        tick();
        check("press_lvl_e6",   32'(bus.key_level), 32'(4'b1000));
        check("press_pulse_e6", 32'(bus.key_press), 32'(4'b1000));
        tick();
        check("press_pulse_e7", 32'(bus.key_press), 32'h0);
        run(30);
        check("hold_press_cnt", 32'(kp_cnt), 32'd0);
        check("hold_level",     32'(bus.key_level), 32'(4'b1000));
        bus.KEY = 4'b1111;
        run(5);
        check("rel_lvl_e5", 32'(bus.key_level), 32'(4'b1000));
        check("rel_press_cnt_a", 32'(kp_cnt), 32'd0);
        run(1);
        check("rel_lvl_e6", 32'(bus.key_level), 32'h0);
        check("rel_press_cnt_b", 32'(kp_cnt), 32'd0);

        // bounce rejection on KEY[1]
        run(5);
        kp_cnt = 0;
        begin
            int bp = 0;
            logic [0:3] bl = '0;
            for (int p = 0; p < 5; p++) begin
                bus.KEY = 4'b1011;
                run(2);
                bp += kp_cnt;
                bl = bl | lvl_or;
                bus.KEY = 4'b1111;
                run(2);
                bp += kp_cnt;
                bl = bl | lvl_or;
            end
            check("bounce_level",     32'(bl), 32'h0);
            check("bounce_press_cnt", 32'(bp), 32'd0);
        end
        bus.KEY = 4'b1011;
        run(5);
        check("settle_lvl_e5", 32'(bus.key_level), 32'h0);
        run(1);
        check("settle_lvl_e6",   32'(bus.key_level), 32'(4'b0100));
        check("settle_pulse_e6", 32'(bus.key_press), 32'(4'b0100));
        run(10);
        check("settle_press_cnt", 32'(kp_cnt), 32'd0);
        bus.KEY = 4'b1111;
        run(10);

        // simultaneous keys and switches
        bus.KEY = 4'b1100;
        bus.SW  = 10'b1000000001;
        run(5);
        check("sim_lvl_e5", 32'(bus.key_level), 32'h0);
        check("sim_sw_e5",  32'(bus.sw_level),  32'h0);
        tick();
        check("sim_press_e6",  32'(bus.key_press), 32'(4'b0011));
        check("sim_klvl_e6",   32'(bus.key_level), 32'(4'b0011));
        check("sim_sw_e6",     32'(bus.sw_level),  32'(10'b1000000001));
        check("sim_change_e6", 32'(bus.sw_change), 32'h1);
        run(5);
        check("sim_press_cnt",  32'(kp_cnt), 32'd0);
        check("sim_change_cnt", 32'(sc_cnt), 32'd0);
        bus.KEY = 4'b1111;
        bus.SW  = 10'b0;
        run(5);
        check("simrel_change_a", 32'(sc_cnt), 32'd0);
        tick();
        check("simrel_sw_e6",     32'(bus.sw_level),  32'h0);
        check("simrel_change_e6", 32'(bus.sw_change), 32'h1);
        check("simrel_press_e6",  32'(bus.key_press), 32'h0);
        run(8);

        // reset mid-count
        bus.KEY = 4'b0111;
        run(3);
        rst = 1'b0;
        #1;
        check("midrst_lvl",   32'(bus.key_level), 32'h0);
        check("midrst_press", 32'(bus.key_press), 32'h0);
        run(3);
        check("midrst_press_cnt", 32'(kp_cnt), 32'd0);
        rst = 1'b1;
        run(5);
        check("midrst_lvl_e5",   32'(bus.key_level), 32'h0);
        check("midrst_cnt_e5",   32'(kp_cnt), 32'd0);
        tick();
        check("midrst_lvl_e6",   32'(bus.key_level), 32'(4'b1000));
        check("midrst_pulse_e6", 32'(bus.key_press), 32'(4'b1000));
        run(5);
        check("midrst_after_cnt", 32'(kp_cnt), 32'd0);
        bus.KEY = 4'b1111;
        run(10);

        // switches already up across reset
        rst = 1'b0;
        bus.SW = 10'h3FF;
        run(3);
        rst = 1'b1;
        #1;
        check("swrst_lvl_rel", 32'(bus.sw_level), 32'h0);
        run(5);
        check("swrst_lvl_e5",    32'(bus.sw_level), 32'h0);
        check("swrst_change_e5", 32'(sc_cnt), 32'd0);
        tick();
        check("swrst_lvl_e6",    32'(bus.sw_level),  32'h3FF);
        check("swrst_change_e6", 32'(bus.sw_change), 32'h1);
        run(5);
        check("swrst_change_cnt", 32'(sc_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
